alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Shares the single 32-bit ALU datapath between NREQ requesters (e.g. scalar pipe, address-gen unit, debug port).
- Round-robin arbitration; valid/ready handshake per requester.
- Operands are held stable in registers during execution; the multiply path gets a configurable multicycle window.
- Returns the registered result and flags on one shared response channel tagged with the requester ID.

Parameters:
NREQ, 2, number of requesters (2..8)
W, 32, operand/result width (fixed to ALU width)
MUL_CYCLES, 2, EXEC cycles granted when ctrl = 3'b110 (multiply), >=1
ID_W, $clog2(NREQ), response ID width (derived, not overridden)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  per-requester accept, one-hot or zero
req_a  in  NREQ*W  operand A, requester i at [i*W +: W]
req_b  in  NREQ*W  operand B, same packing
req_ctrl  in  NREQ*3  ALU control, requester i at [i*3 +: 3]
alu_a  out  W  to ALU BussA
alu_b  out  W  to ALU BussB
alu_ctrl  out  3  to ALU ALUControl
alu_result  in  W  from ALU Output
alu_flags  in  5  from ALU {negative, overflow, gt, zero, CarryOut}, bit4..bit0
resp_valid  out  1  response valid
resp_ready  in  1  response accept
resp_id  out  ID_W  index of the requester that owns the response
resp_data  out  W  registered result
resp_flags  out  5  registered flags, same order as alu_flags
resp_err  out  1  illegal ctrl (3'b111) indicator
busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0):
  - state = IDLE, rr_ptr = 0, exec counter = 0.
  - alu_a/alu_b/alu_ctrl = 0; resp_valid = 0, resp_id = 0, resp_data = 0, resp_flags = 0, resp_err = 0.
  - Any in-flight operation is discarded, with no response. Release is synchronous to clk.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant g = first i with req_valid[i], searching from rr_ptr upward, modulo NREQ.
  - req_ready[g] = 1 combinationally. All other req_ready bits are 0, and all are 0 outside IDLE.
  - On the accept edge:
    - operand regs <= req_a[g], req_b[g], req_ctrl[g]; id_reg <= g.
    - rr_ptr <= (g+1) mod NREQ.
    - counter <= (ctrl==3'b110) ? MUL_CYCLES-1 : 0.
    - state <= EXEC.
  - With no req_valid, stay in IDLE; rr_ptr is unchanged.
- EXEC:
  - alu_a/alu_b/alu_ctrl come straight from the operand regs and stay stable for the whole EXEC period (multicycle path constraint on the multiply).
  - If counter != 0: decrement.
  - If counter == 0: capture into resp_data/resp_flags, set resp_id <= id_reg, state <= RESP.
- Latency: resp_valid rises 1 cycle after the accept edge for non-multiply ops, MUL_CYCLES cycles after it for multiply.
- Illegal ctrl = 3'b111:
  - Accepted normally, 1 EXEC cycle.
  - resp_data = 0, resp_flags = 0, resp_err = 1. resp_err = 0 for all legal ops.
- RESP:
  - resp_valid = 1; resp_* stay stable until the handshake.
  - When resp_valid & resp_ready on an edge: state <= IDLE, resp_valid <= 0.
  - No new request is accepted in the same cycle as the response handshake. Peak throughput is one op per 3 cycles (non-mul).
- Backpressure: resp_ready low holds RESP indefinitely. Requesters stay unserved; their req_valid must stay asserted with stable operands until req_ready.
- Fairness: a requester that is continuously valid is granted within NREQ grants.
- Simultaneous requests: resolved purely by rr_ptr. A requester that drops req_valid before its grant simply loses its turn.
- Arithmetic and flag semantics belong to the ALU. This block only captures its outputs and never modifies them, except in the illegal-op case.

Test Plan:
- Add: req0 a=5, b=7, ctrl=000, resp_ready=1 -> req_ready[0] in the same cycle; resp_valid 1 cycle after accept; resp_data=12, resp_flags=5'b00000, resp_id=0, resp_err=0; busy returns to 0 after the handshake.
- Contention: req0 and req1 both valid from reset (a=3, b=3, ctrl=010) -> grant order 0,1,0,1 over four ops; each sub gives resp_data=0 with zero flag bit1=1.
- Multiply with MUL_CYCLES=3: req1 a=6, b=7, ctrl=110 -> alu_a/alu_b/alu_ctrl stable for 3 cycles; resp_valid 3 cycles after accept; resp_data=42, resp_id=1.
- Backpressure: resp_ready=0 for 10 cycles after an add (a=1, b=2) while req0 is valid again -> resp_valid held, resp_data stays 3, req_ready all 0; after resp_ready=1, the next accept occurs no earlier than one cycle after the handshake.
- Illegal op: ctrl=111, a=9, b=9 -> resp_err=1, resp_data=0, resp_flags=0; the following legal op has resp_err=0.
- Reset mid-op: assert rst_n=0 during EXEC of a multiply -> all outputs 0 immediately (async), no response after release, rr_ptr=0 so req0 wins first when both are valid.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sharing of one ALU datapath between NREQ requesters
module alu_share_arbiter #(
    parameter int NREQ       = 2,
    parameter int W          = 32,
    parameter int MUL_CYCLES = 2,
    localparam int ID_W      = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*W-1:0]    req_a,
    input  logic [NREQ*W-1:0]    req_b,
    input  logic [NREQ*3-1:0]    req_ctrl,
    output logic [W-1:0]         alu_a,
    output logic [W-1:0]         alu_b,
    output logic [2:0]           alu_ctrl,
    input  logic [W-1:0]         alu_result,
    input  logic [4:0]           alu_flags,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [ID_W-1:0]      resp_id,
    output logic [W-1:0]         resp_data,
    output logic [4:0]           resp_flags,
    output logic                 resp_err,
    output logic                 busy
);

    localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [2:0] CTRL_MUL = 3'b110;
    localparam logic [2:0] CTRL_ILL = 3'b111;
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NREQ - 1);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [ID_W-1:0]   r_rr_ptr;
    logic [ID_W-1:0]   r_id;
    logic [CNT_W-1:0]  r_cnt;
    logic [W-1:0]      r_op_a;
    logic [W-1:0]      r_op_b;
    logic [2:0]        r_op_ctrl;
    logic [W-1:0]      r_resp_data;
    logic [4:0]        r_resp_flags;
    logic              r_resp_err;
    logic [ID_W-1:0]   r_resp_id;

    logic              w_grant_found;
    logic [ID_W-1:0]   w_grant_idx;
    logic              w_accept;
    logic [2:0]        w_sel_ctrl;

    function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NREQ) s = s - NREQ;
        return ID_W'(s);
    endfunction

    // Walk downward so the requester closest to rr_ptr is the last (winning) assignment.
    always_comb begin
        w_grant_found = 1'b0;
        w_grant_idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[wrap_idx(r_rr_ptr, k)]) begin
                w_grant_found = 1'b1;
                w_grant_idx   = wrap_idx(r_rr_ptr, k);
            end
        end
    end

    assign w_accept   = (r_state == S_IDLE) && w_grant_found;
    assign w_sel_ctrl = req_ctrl[w_grant_idx*3 +: 3];

    always_comb begin
        req_ready = '0;
        if (w_accept) req_ready[w_grant_idx] = 1'b1;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_grant_found) w_next_state = S_EXEC;
            S_EXEC:  if (r_cnt == '0) w_next_state = S_RESP;
            S_RESP:  if (resp_ready) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr     <= '0;
            r_id         <= '0;
            r_cnt        <= '0;
            r_op_a       <= '0;
            r_op_b       <= '0;
            r_op_ctrl    <= '0;
            r_resp_data  <= '0;
            r_resp_flags <= '0;
            r_resp_err   <= 1'b0;
            r_resp_id    <= '0;
        end else begin
            if (w_accept) begin
                r_op_a    <= req_a[w_grant_idx*W +: W];
                r_op_b    <= req_b[w_grant_idx*W +: W];
                r_op_ctrl <= w_sel_ctrl;
                r_id      <= w_grant_idx;
                r_rr_ptr  <= (w_grant_idx == LAST_ID) ? '0 : w_grant_idx + 1'b1;
                r_cnt     <= (w_sel_ctrl == CTRL_MUL) ? MUL_LOAD : '0;
            end
            if (r_state == S_EXEC) begin
                if (r_cnt != '0) begin
                    r_cnt <= r_cnt - 1'b1;
                end else begin
                    // Illegal op returns zeros with the error bit instead of whatever the ALU produced.
                    r_resp_data  <= (r_op_ctrl == CTRL_ILL) ? '0 : alu_result;
                    r_resp_flags <= (r_op_ctrl == CTRL_ILL) ? '0 : alu_flags;
                    r_resp_err   <= (r_op_ctrl == CTRL_ILL);
                    r_resp_id    <= r_id;
                end
            end
        end
    end

    assign alu_a      = r_op_a;
    assign alu_b      = r_op_b;
    assign alu_ctrl   = r_op_ctrl;
    assign resp_valid = (r_state == S_RESP);
    assign resp_id    = r_resp_id;
    assign resp_data  = r_resp_data;
    assign resp_flags = r_resp_flags;
    assign resp_err   = r_resp_err;
    assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - scoreboard bench for alu_share_arbiter with a behavioural ALU
module tb_alu_share_arbiter;

    localparam int NREQ = 2;
    localparam int W    = 32;
    localparam int MULC = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ*3-1:0] req_ctrl;
    logic [W-1:0]      alu_a, alu_b, alu_result;
    logic [2:0]        alu_ctrl;
    logic [4:0]        alu_flags;
    logic              resp_valid, resp_ready, resp_err, busy;
    logic [0:0]        resp_id;
    logic [W-1:0]      resp_data;
    logic [4:0]        resp_flags;

    alu_share_arbiter #(.NREQ(NREQ), .W(W), .MUL_CYCLES(MULC)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_ctrl(req_ctrl),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_data(resp_data), .resp_flags(resp_flags),
        .resp_err(resp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // Flags {neg, ovf, gt, zero, carry}; ctrl 111 yields a|b so the forced zeros are observable.
    function automatic logic [36:0] alu_model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
        logic [32:0] s;
        logic [31:0] r;
        logic        ovf, cy;
        ovf = 1'b0;
        cy  = 1'b0;
        case (c)
            3'b000: begin s = {1'b0, a} + {1'b0, b}; r = s[31:0]; cy = s[32]; ovf = (a[31] == b[31]) && (r[31] != a[31]); end
            3'b010: begin r = a - b; ovf = (a[31] != b[31]) && (r[31] != a[31]); end
            3'b110: r = a * b;
            3'b001: r = a & b;
            default: r = a | b;
        endcase
        return {r[31], ovf, ($signed(a) > $signed(b)), (r == 32'd0), cy, r};
    endfunction

    assign {alu_flags, alu_result} = alu_model(alu_a, alu_b, alu_ctrl);

    typedef struct {
        logic [0:0]  id;
        logic [31:0] data;
        logic [4:0]  flags;
        logic        err;
        int          lat;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  ctrl;
    } exp_t;

    exp_t q[$];
    int   glog[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   acc_edge;
    bit   m_idle = 1'b1;
    int   m_rr   = 0;
    bit   seen;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        logic [NREQ-1:0] exp_rdy;
        int g;
        logic [36:0] m;
        exp_t it;
        if (!rst_n) begin
            q.delete();
            m_idle = 1'b1;
            m_rr   = 0;
            seen   = 1'b0;
        end else begin
            exp_rdy = '0;
            g = 0;
            if (m_idle) begin
                for (int k = NREQ - 1; k >= 0; k--) begin
                    if (req_valid[(m_rr + k) % NREQ]) g = (m_rr + k) % NREQ;
                end
                if (req_valid != '0) exp_rdy[g] = 1'b1;
            end
            chk("req_ready", req_ready, exp_rdy);
            chk("busy", busy, !m_idle);
            if (exp_rdy != '0) begin
                it.a    = req_a[g*W +: W];
                it.b    = req_b[g*W +: W];
                it.ctrl = req_ctrl[g*3 +: 3];
                m       = alu_model(it.a, it.b, it.ctrl);
                it.id   = g[0:0];
                it.err  = (it.ctrl == 3'b111);
                it.data = it.err ? 32'd0 : m[31:0];
                it.flags = it.err ? 5'd0 : m[36:32];
                it.lat  = (it.ctrl == 3'b110) ? MULC : 1;
                q.push_back(it);
                glog.push_back(g);
                m_rr     = (g + 1) % NREQ;
                m_idle   = 1'b0;
                acc_edge = cyc + 1;
                seen     = 1'b0;
            end else if (!m_idle && q.size() > 0) begin
                if (!resp_valid && !seen) begin
                    chk("alu_a_hold", alu_a, q[0].a);
                    chk("alu_b_hold", alu_b, q[0].b);
                    chk("alu_ctrl_hold", alu_ctrl, q[0].ctrl);
                end
                if (resp_valid) begin
                    if (!seen) chk("latency", cyc - acc_edge, q[0].lat);
                    seen = 1'b1;
                    chk("resp_id", resp_id, q[0].id);
                    chk("resp_data", resp_data, q[0].data);
                    chk("resp_flags", resp_flags, q[0].flags);
                    chk("resp_err", resp_err, q[0].err);
                    if (resp_ready) begin
                        void'(q.pop_front());
                        m_idle = 1'b1;
                    end
                end
            end else if (m_idle) begin
                chk("resp_valid_idle", resp_valid, 1'b0);
            end
        end
    end

    task automatic issue(input int i, input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
        req_a[i*W +: W]  = a;
        req_b[i*W +: W]  = b;
        req_ctrl[i*3 +: 3] = c;
        req_valid[i] = 1'b1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (req_ready[i]) begin
                @(posedge clk);
                #1;
                req_valid[i] = 1'b0;
                return;
            end
        end
        chk("accept_timeout", 1'b0, 1'b1);
        req_valid[i] = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int base;
        rst_n      = 1'b0;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        req_ctrl   = '0;
        resp_ready = 1'b1;
        #1;
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_ctrl", alu_ctrl, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_data", resp_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_req_ready", req_ready, 0);
        idle_cycles(2);
        rst_n = 1'b1;

        // Contention: both valid from reset, expected order 0,1,0,1
        base = glog.size();
        fork
            begin issue(0, 3, 3, 3'b010); issue(0, 3, 3, 3'b010); end
            begin issue(1, 3, 3, 3'b010); issue(1, 3, 3, 3'b010); end
        join
        idle_cycles(4);
        chk("grant0", glog[base],     0);
        chk("grant1", glog[base + 1], 1);
        chk("grant2", glog[base + 2], 0);
        chk("grant3", glog[base + 3], 1);

        issue(0, 5, 7, 3'b000);
        idle_cycles(4);
        chk("add_busy_done", busy, 0);

        issue(1, 6, 7, 3'b110);
        idle_cycles(6);

        // Backpressure: response held 10 cycles while req0 waits
        resp_ready = 1'b0;
        fork
            begin issue(0, 1, 2, 3'b000); issue(0, 4, 4, 3'b000); end
            begin idle_cycles(12); resp_ready = 1'b1; end
        join
        idle_cycles(4);

        issue(0, 9, 9, 3'b111);
        issue(1, 32'hFFFF_FFFF, 1, 3'b000);
        idle_cycles(4);

        // Reset during a multiply's EXEC
        issue(1, 6, 7, 3'b110);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_alu_a", alu_a, 0);
        chk("mid_rst_alu_b", alu_b, 0);
        chk("mid_rst_alu_ctrl", alu_ctrl, 0);
        chk("mid_rst_resp_valid", resp_valid, 0);
        chk("mid_rst_busy", busy, 0);
        req_a = {32'd2, 32'd1};
        req_b = {32'd2, 32'd1};
        req_ctrl = '0;
        req_valid = 2'b11;
        idle_cycles(2);
        base = glog.size();
        rst_n = 1'b1;
        fork
            issue(0, 1, 1, 3'b000);
            issue(1, 2, 2, 3'b000);
        join
        idle_cycles(6);
        chk("post_rst_first_grant", glog[base], 0);
        chk("post_rst_second_grant", glog[base + 1], 1);
        chk("scoreboard_empty", q.size(), 0);
        chk("final_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
